// File: rtl/video_timing_ctrl_pkg.sv
// Shared widths, default 720p raster timing and FSM state type for the video timing block.
// No logic of its own, so it adds no latency.
// No flow control; the raster runs freely once started.
package video_timing_ctrl_pkg;

  // Coordinate bus widths into the pixel generator
  localparam int VIDEO_X_BITWIDTH = 12;
  localparam int VIDEO_Y_BITWIDTH = 11;

  // 1280x720p60 default timing
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  typedef enum logic [1:0] {
    VTC_IDLE     = 2'd0,
    VTC_RUN      = 2'd1,
    VTC_STOPPING = 2'd2
  } vtc_state_t;

  // True when 'value' can be represented in an unsigned field of 'width' bits
  function automatic bit fits_width(input int value, input int width);
    return (value >= 0) && (value < (1 << width));
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: counts active, front porch, sync, back porch, then wraps.
// Count is registered; wrap/active/sync decode combinationally from the count register.
// No backpressure; advances whenever enable_i is high, clear_i overrides enable_i.
module video_axis_counter #(
  parameter int ACTIVE = 4,
  parameter int FP     = 1,
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  parameter int W      = 8
) (
  input  logic         I_clk_pixel,
  input  logic         I_reset_n,
  input  logic         enable_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step and wrap at the last position of the axis
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = (count_q == LAST);
  assign active_o = (count_q < ACT_END);
  assign sync_o   = (count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: h/v counters, coordinate outputs and DE/HSYNC/VSYNC/frame-start strobes.
// pixX/pixY are combinational from the counters; strobes are registered (1 cycle) to meet generator rgb.
// No backpressure; I_run start/stop only takes effect on frame boundaries so frames are never cut.
module video_timing_ctrl
  import video_timing_ctrl_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                        I_clk_pixel,
  input  logic                        I_reset_n,
  input  logic                        I_run,
  output logic [VIDEO_X_BITWIDTH-1:0] pixX,
  output logic [VIDEO_Y_BITWIDTH-1:0] pixY,
  output logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
  output logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
  output logic                        O_de,
  output logic                        O_hs,
  output logic                        O_vs,
  output logic                        O_frame_start,
  output logic                        O_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to build a raster whose last position does not fit the coordinate buses
  if (!fits_width(H_TOTAL - 1, VIDEO_X_BITWIDTH)) begin : g_h_width_err
    $error("video_timing_ctrl: H_TOTAL-1 does not fit VIDEO_X_BITWIDTH");
  end
  if (!fits_width(V_TOTAL - 1, VIDEO_Y_BITWIDTH)) begin : g_v_width_err
    $error("video_timing_ctrl: V_TOTAL-1 does not fit VIDEO_Y_BITWIDTH");
  end

  vtc_state_t state_q;
  vtc_state_t state_d;

  logic de_q;
  logic hs_q;
  logic vs_q;
  logic fs_q;
  logic busy_q;

  logic [VIDEO_X_BITWIDTH-1:0] h_count;
  logic [VIDEO_Y_BITWIDTH-1:0] v_count;
  logic h_wrap, h_active, h_sync;
  logic v_wrap, v_active, v_sync;

  logic running;
  logic frame_end;
  logic de_d, hs_d, vs_d, fs_d;

  // IDLE holds both counters at the origin; RUN and STOPPING both scan
  assign running   = (state_q != VTC_IDLE);
  assign frame_end = h_wrap && v_wrap;

  video_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (VIDEO_X_BITWIDTH)
  ) u_h_counter (
    .I_clk_pixel (I_clk_pixel),
    .I_reset_n   (I_reset_n),
    .enable_i    (running),
    .clear_i     (!running),
    .count_o     (h_count),
    .wrap_o      (h_wrap),
    .active_o    (h_active),
    .sync_o      (h_sync)
  );

  // Vertical axis steps once per line, on the horizontal wrap
  video_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VIDEO_Y_BITWIDTH)
  ) u_v_counter (
    .I_clk_pixel (I_clk_pixel),
    .I_reset_n   (I_reset_n),
    .enable_i    (running && h_wrap),
    .clear_i     (!running),
    .count_o     (v_count),
    .wrap_o      (v_wrap),
    .active_o    (v_active),
    .sync_o      (v_sync)
  );

  // Decode of the current counter position; forced inactive while idle
  assign de_d = running && h_active && v_active;
  assign hs_d = running && h_sync;
  assign vs_d = running && v_sync;
  assign fs_d = running && (h_count == '0) && (v_count == '0);

  // Next state: stopping is only honoured at the end of a frame, and a frame-end
  // seen in RUN with I_run low still goes to STOPPING so the following frame is whole
  always_comb begin
    state_d = state_q;
    case (state_q)
      VTC_IDLE: begin
        if (I_run) state_d = VTC_RUN;
      end
      VTC_RUN: begin
        if (!I_run) state_d = VTC_STOPPING;
      end
      VTC_STOPPING: begin
        if (I_run) begin
          state_d = VTC_RUN;
        end else if (frame_end) begin
          state_d = VTC_IDLE;
        end
      end
      default: state_d = VTC_IDLE;
    endcase
  end

  // State register plus one-cycle-delayed strobes that line up with the generator's rgb
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= VTC_IDLE;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      busy_q  <= (state_d != VTC_IDLE);
    end
  end

  // Coordinates are zeroed outside the active window so the generator sees a clean origin
  assign pixX = de_d ? h_count : '0;
  assign pixY = de_d ? v_count : '0;

  assign screenWidth  = VIDEO_X_BITWIDTH'(H_ACTIVE);
  assign screenHeight = VIDEO_Y_BITWIDTH'(V_ACTIVE);

  assign O_de          = de_q;
  assign O_hs          = HSYNC_POL ? hs_q : !hs_q;
  assign O_vs          = VSYNC_POL ? vs_q : !vs_q;
  assign O_frame_start = fs_q;
  assign O_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a small 8x6 raster with a scoreboard of expected strobes.
// Strobes are expected one cycle after the coordinate that produced them.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_video_timing_ctrl;
  import video_timing_ctrl_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  logic clk;
  logic reset_n;
  logic run;
  logic [VIDEO_X_BITWIDTH-1:0] pix_x;
  logic [VIDEO_Y_BITWIDTH-1:0] pix_y;
  logic [VIDEO_X_BITWIDTH-1:0] screen_w;
  logic [VIDEO_Y_BITWIDTH-1:0] screen_h;
  logic de, hs, vs, fs, busy;
  logic [23:0] rgb;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  video_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) dut (
    .I_clk_pixel   (clk),
    .I_reset_n     (reset_n),
    .I_run         (run),
    .pixX          (pix_x),
    .pixY          (pix_y),
    .screenWidth   (screen_w),
    .screenHeight  (screen_h),
    .O_de          (de),
    .O_hs          (hs),
    .O_vs          (vs),
    .O_frame_start (fs),
    .O_busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in pixel generator: blue border, grey interior, one register stage
  always_ff @(posedge clk) begin
    if ((pix_x == 0) || (pix_y == 0) || (pix_x == HA - 1) || (pix_y == VA - 1))
      rgb <= 24'h0000ff;
    else
      rgb <= 24'h404040;
  end

  function automatic exp_t exp_idle();
    exp_t e;
    e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.fs = 1'b0; e.rgb = 24'h0;
    return e;
  endfunction

  // Expected decode for the t-th cycle of a free-running raster started at the origin
  function automatic exp_t exp_at(input int t);
    exp_t e;
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    e.de  = (h < HA) && (v < VA);
    e.hs  = (h >= HA + HF) && (h <= HA + HF + HS - 1);
    e.vs  = (v >= VA + VF) && (v <= VA + VF + VS - 1);
    e.fs  = (h == 0) && (v == 0);
    e.rgb = ((h == 0) || (v == 0) || (h == HA - 1) || (v == VA - 1)) ? 24'h0000ff : 24'h404040;
    return e;
  endfunction

  // Reset, release into IDLE, then request video; returns at the first RUN cycle (t=0)
  task automatic start_run();
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run     = 1'b1;
    repeat (2) @(negedge clk);
    if ({de, hs, vs, fs, busy} !== 5'b00000) begin
      bad++; $display("FAIL reset_strobes: got %b expected 00000", {de, hs, vs, fs, busy});
    end
    total++;
    if (pix_x !== '0 || pix_y !== '0) begin
      bad++; $display("FAIL reset_pix: got (%0d,%0d) expected (0,0)", pix_x, pix_y);
    end
    total++;
    if (screen_w !== VIDEO_X_BITWIDTH'(HA) || screen_h !== VIDEO_Y_BITWIDTH'(VA)) begin
      bad++; $display("FAIL screen_size: got %0dx%0d expected %0dx%0d", screen_w, screen_h, HA, VA);
    end
    total++;
    reset_n = 1'b1;
    #1;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_before_sample: got %b expected 0", busy);
    end
    total++;
    @(negedge clk);
    if (busy !== 1'b1 || de !== 1'b0) begin
      bad++; $display("FAIL busy_rise: got busy=%b de=%b expected busy=1 de=0", busy, de);
    end
    total++;
    @(negedge clk);
    if (fs !== 1'b1 || de !== 1'b1 || pix_x !== VIDEO_X_BITWIDTH'(1)) begin
      bad++; $display("FAIL first_frame_start: got fs=%b de=%b x=%0d expected fs=1 de=1 x=1", fs, de, pix_x);
    end
    total++;
  endtask

  // Free-running scan with optional stop and resume; live_last is the last cycle still inside the raster
  task automatic test_raster(input string tag, input int n, input int drop_t,
                             input int resume_t, input int live_last);
    exp_t e;
    int fs_prev;
    int ex, ey;
    bit live;
    fs_prev = -1;
    start_run();
    sb.delete();
    sb.push_back(exp_idle());
    for (int t = 0; t < n; t++) begin
      live = (t <= live_last);
      e = sb.pop_front();
      ex = (live && exp_at(t).de) ? t % HT : 0;
      ey = (live && exp_at(t).de) ? (t / HT) % VT : 0;
      if (pix_x !== VIDEO_X_BITWIDTH'(ex) || pix_y !== VIDEO_Y_BITWIDTH'(ey)) begin
        bad++; $display("FAIL %s_pix t=%0d: got (%0d,%0d) expected (%0d,%0d)", tag, t, pix_x, pix_y, ex, ey);
      end
      total++;
      if ({de, hs, vs, fs} !== {e.de, e.hs, e.vs, e.fs}) begin
        bad++; $display("FAIL %s_strobes t=%0d: got de/hs/vs/fs=%b expected %b", tag, t,
                        {de, hs, vs, fs}, {e.de, e.hs, e.vs, e.fs});
      end
      total++;
      if (e.de && rgb !== e.rgb) begin
        bad++; $display("FAIL %s_rgb t=%0d: got %06h expected %06h", tag, t, rgb, e.rgb);
      end
      if (e.de) total++;
      if (busy !== live) begin
        bad++; $display("FAIL %s_busy t=%0d: got %b expected %b", tag, t, busy, live);
      end
      total++;
      if (fs === 1'b1) begin
        if (fs_prev >= 0) begin
          if (t - fs_prev != FT) begin
            bad++; $display("FAIL %s_fs_spacing t=%0d: got %0d expected %0d", tag, t, t - fs_prev, FT);
          end
          total++;
        end
        fs_prev = t;
      end
      sb.push_back(live ? exp_at(t) : exp_idle());
      if (t == drop_t) run = 1'b0;
      if (t == resume_t) run = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_run();
    repeat (HT + 2) @(negedge clk);
    if (pix_x !== VIDEO_X_BITWIDTH'(2) || pix_y !== VIDEO_Y_BITWIDTH'(1) || de !== 1'b1) begin
      bad++; $display("FAIL midframe_pos: got (%0d,%0d) de=%b expected (2,1) de=1", pix_x, pix_y, de);
    end
    total++;
    reset_n = 1'b0;
    #1;
    if ({de, hs, vs, fs, busy} !== 5'b00000 || pix_x !== '0 || pix_y !== '0) begin
      bad++; $display("FAIL midframe_async_reset: got strobes=%b pix=(%0d,%0d) expected 00000 (0,0)",
                      {de, hs, vs, fs, busy}, pix_x, pix_y);
    end
    total++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    if (busy !== 1'b1 || pix_x !== '0 || pix_y !== '0 || fs !== 1'b0) begin
      bad++; $display("FAIL restart_origin: got busy=%b pix=(%0d,%0d) fs=%b expected 1 (0,0) 0",
                      busy, pix_x, pix_y, fs);
    end
    total++;
    @(negedge clk);
    if (fs !== 1'b1 || de !== 1'b1 || pix_x !== VIDEO_X_BITWIDTH'(1)) begin
      bad++; $display("FAIL restart_frame_start: got fs=%b de=%b x=%0d expected 1 1 1", fs, de, pix_x);
    end
    total++;
  endtask

  initial begin
    reset_n = 1'b0;
    run     = 1'b0;
    test_reset();
    test_raster("scan", 2 * FT + 4, -1, -1, 1 << 30);
    test_raster("stop", FT + 20, HT, -1, FT - 1);
    test_raster("stop_at_end", 2 * FT + 20, FT - 1, -1, 2 * FT - 1);
    test_raster("back_to_back", 2 * FT + 10, HT, 3 * HT, 1 << 30);
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Raster sequencer for the HDMI pixel pipeline. It scans horizontal and vertical counters through active, front-porch, sync and back-porch intervals. It drives `pixX`/`pixY`/`screenWidth`/`screenHeight` into the pixel generator, and emits DE/HSYNC/VSYNC delayed one cycle so they align with the generator's registered RGB. Start/stop is frame-synchronous: output never contains a truncated frame.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of O_hs
- VSYNC_POL, 1, asserted level of O_vs
- I_clk_pixel  in  1  pixel clock
- I_reset_n  in  1  reset I_reset_n, asynchronous, active-low; clock I_clk_pixel
- I_run  in  1  level request to generate video
- pixX  out  VIDEO_X_BITWIDTH  current column (0 outside active)
- pixY  out  VIDEO_Y_BITWIDTH  current row (0 outside active)
- screenWidth  out  VIDEO_X_BITWIDTH  constant H_ACTIVE
- screenHeight  out  VIDEO_Y_BITWIDTH  constant V_ACTIVE
- O_de  out  1  data enable, aligned with generator rgb
- O_hs  out  1  hsync, aligned with rgb
- O_vs  out  1  vsync, aligned with rgb
- O_frame_start  out  1  one-cycle pulse at (hcnt,vcnt)=(0,0), aligned with rgb
- O_busy  out  1  state != IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Order per axis: active, FP, sync, BP.
- H_TOTAL-1 must fit VIDEO_X_BITWIDTH and V_TOTAL-1 must fit VIDEO_Y_BITWIDTH. Violation is an elaboration error.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments only on hcnt wrap; it wraps at V_TOTAL-1.
- active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- hsync asserts for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync asserts for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only at hcnt=0.
- pixX = active ? hcnt : 0. pixY = active ? vcnt : 0. Both are combinational from the counter registers.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: counters held at 0, decode forced inactive. I_run=1 moves to RUN.
  - RUN: counters advance every cycle. I_run=0 moves to STOPPING.
  - STOPPING: counters advance. At hcnt=H_TOTAL-1 && vcnt=V_TOTAL-1, counters go to 0 and the state goes to IDLE. I_run=1 returns to RUN with no counter disturbance.
- Simultaneous I_run=0 and frame-end cycle in RUN: go to STOPPING, not IDLE. The next full frame is emitted.
- Reset mid-frame: all state is cleared immediately (asynchronous). Outputs go to reset values; no partial-frame completion.

## Timing
- Reset values: counters 0, state IDLE.
- Output reset values: O_de=0, O_hs=!HSYNC_POL, O_vs=!VSYNC_POL, O_frame_start=0, O_busy=0, pixX=0, pixY=0.
- First RUN cycle has hcnt=0, vcnt=0. That is the cycle after the I_run=1 sample in IDLE.
- pixX/pixY present coordinate at cycle N. The generator returns rgb at N+1.
- O_de/O_hs/O_vs/O_frame_start are registered decodes of cycle N, valid at N+1 (latency 1).
- In IDLE the registered outputs show inactive levels one cycle after entry.
- O_busy is registered from next-state: rises the cycle after I_run is sampled high; falls the cycle after the last frame-end cycle.

## Structure
- configPackage holds:
  - VIDEO_X_BITWIDTH, VIDEO_Y_BITWIDTH
  - 720p default timing constants
  - typedef enum for the FSM states (vtc_state_t)
- One sub-module: video_axis_counter.
  - Parameters ACTIVE/FP/SYNC/BP; inputs enable and clear.
  - Outputs count, wrap, active, sync.
  - Instantiated twice: horizontal with enable=running; vertical with enable=h wrap.

## Test plan
- Small-raster params used below: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), POL=1.
- Reset asserted with I_run=1 -> all outputs at reset values, O_hs=O_vs=0. Release -> O_busy=1 one cycle after the first I_run sample.
- Run the small raster -> O_de high 4 of every 8 cycles on lines 0-2. O_hs high at hcnt 5-6 (observed at 6-7). O_vs high for the full line vcnt=4. O_frame_start every 48 cycles.
- Check pixX/pixY each cycle -> sequence (0,0),(1,0),(2,0),(3,0), then 0 for four cycles, then (0,1). Generator border rgb 0000ff appears at the same cycle as O_de.
- Deassert I_run at vcnt=1 -> frame completes through vcnt=5/hcnt=7. O_busy falls next cycle. Counters stay at 0 and O_de stays 0 thereafter.
- Deassert I_run, then reassert it in STOPPING at vcnt=3 -> no gap. The next O_frame_start is exactly 48 cycles after the previous one.
- Pulse I_reset_n low at hcnt=2/vcnt=1 -> immediate reset values. After release with I_run=1, restart from (0,0) with O_frame_start.
